// File: rtl/alu_pkg.sv
// Shared ALU operation codes, op-class encoding and instruction field positions
// for the RV32 single-cycle datapath.
package alu_pkg;

  typedef enum logic [3:0] {
    AluAnd  = 4'b0000,
    AluOr   = 4'b0001,
    AluAdd  = 4'b0010,
    AluXor  = 4'b0011,
    AluSll  = 4'b0100,
    AluSrl  = 4'b0101,
    AluSub  = 4'b0110,
    AluSlt  = 4'b0111,
    AluSltu = 4'b1000,
    AluSra  = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    ClsMem    = 2'b00,
    ClsBranch = 2'b01,
    ClsRtype  = 2'b10,
    ClsItype  = 2'b11
  } alu_op_cls_e;

  localparam int unsigned Funct3Lsb = 12;
  localparam int unsigned Funct3Msb = 14;
  localparam int unsigned Funct7Lsb = 25;
  localparam int unsigned Funct7Msb = 31;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Shr    = 3'b101;

  // Operation selected by funct3 alone, before any funct7 qualification.
  function automatic alu_op_t base_op(logic [2:0] funct3);
    unique case (funct3)
      3'b000:  return AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/alu_control.sv
// ALU operation decode: combinational op code and illegal flag from funct3/funct7
// and the op class, plus a registered op code and a sticky illegal flag.
module alu_control
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [1:0]  alu_op_sel,
  output logic [3:0]  alu_op,
  output logic        illegal,
  output logic [3:0]  alu_op_q,
  output logic        illegal_seen
);

  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_t    op_d;
  logic       illegal_d;
  alu_op_t    op_q;
  logic       seen_q;

  assign funct3 = instruction[Funct3Msb:Funct3Lsb];
  assign funct7 = instruction[Funct7Msb:Funct7Lsb];

  always_comb begin
    op_d      = AluAdd;
    illegal_d = 1'b0;
    unique case (alu_op_cls_e'(alu_op_sel))
      ClsMem:    op_d = AluAdd;
      ClsBranch: op_d = AluSub;
      ClsRtype: begin
        op_d = base_op(funct3);
        if (funct7 == F7Alt && funct3 == F3AddSub) begin
          op_d = AluSub;
        end else if (funct7 == F7Alt && funct3 == F3Shr) begin
          op_d = AluSra;
        end else if (funct7 != F7Base) begin
          illegal_d = 1'b1;
        end
      end
      ClsItype: begin
        // funct7 is immediate data except for the shift encodings.
        op_d = base_op(funct3);
        if (funct3 == F3Shr && funct7 == F7Alt) begin
          op_d = AluSra;
        end else if ((funct3 == F3Sll || funct3 == F3Shr) && funct7 != F7Base) begin
          illegal_d = 1'b1;
        end
      end
      default: op_d = AluAdd;
    endcase
    if (illegal_d) begin
      op_d = AluAdd;
    end
  end

  assign alu_op  = op_d;
  assign illegal = illegal_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= AluAdd;
      seen_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      seen_q <= seen_q | illegal_d;
    end
  end

  assign alu_op_q     = op_q;
  assign illegal_seen = seen_q;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed decode vectors, randomized
// stimulus against a table-driven reference model, and async reset behaviour.
module tb_alu_control;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [1:0]  alu_op_sel;
  logic [3:0]  alu_op;
  logic        illegal;
  logic [3:0]  alu_op_q;
  logic        illegal_seen;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [3:0] mdl_q;
  logic       mdl_seen;

  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSra = 4'b1001;
  // Op by funct3 when funct7 is zero: ADD SLL SLT SLTU XOR SRL OR AND.
  localparam logic [3:0] F3Table [8] = '{4'b0010, 4'b0100, 4'b0111, 4'b1000,
                                         4'b0011, 4'b0101, 4'b0001, 4'b0000};

  alu_control u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .alu_op_sel   (alu_op_sel),
    .alu_op       (alu_op),
    .illegal      (illegal),
    .alu_op_q     (alu_op_q),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [1:0] sel, input logic [31:0] ins,
                                     output logic [3:0] op, output logic ill);
    int f3;
    int f7;
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    op  = OpAdd;
    ill = 1'b0;
    case (sel)
      2'd0: op = OpAdd;
      2'd1: op = OpSub;
      2'd2: begin
        if (f7 == 0) op = F3Table[f3];
        else if (f7 == 32 && f3 == 0) op = OpSub;
        else if (f7 == 32 && f3 == 5) op = OpSra;
        else ill = 1'b1;
      end
      default: begin
        if (f3 == 1) ill = (f7 != 0);
        else if (f3 == 5) ill = !(f7 == 0 || f7 == 32);
        op = (f3 == 5 && f7 == 32) ? OpSra : F3Table[f3];
      end
    endcase
    if (ill) op = OpAdd;
  endfunction

  // Drive one vector mid-cycle, check the combinational decode against
  // (exp_op, exp_ill), then check the registered outputs after the next edge.
  task automatic step(input string tag, input logic [1:0] sel, input logic [31:0] ins,
                      input logic [3:0] exp_op, input logic exp_ill);
    @(negedge clk);
    alu_op_sel  = sel;
    instruction = ins;
    #1;
    check({tag, ".alu_op"}, 32'(alu_op), 32'(exp_op));
    check({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
    @(posedge clk);
    mdl_q    = exp_op;
    mdl_seen = mdl_seen | exp_ill;
    #1;
    check({tag, ".alu_op_q"}, 32'(alu_op_q), 32'(mdl_q));
    check({tag, ".illegal_seen"}, 32'(illegal_seen), 32'(mdl_seen));
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] ins;
    logic [3:0]  op;
    logic        ill;
  } vec_t;

  vec_t dir [16];

  initial begin
    logic [3:0]  m_op;
    logic        m_ill;
    logic [1:0]  r_sel;
    logic [31:0] r_ins;

    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    instruction = 32'h0;
    alu_op_sel  = 2'b01;
    mdl_q       = OpAdd;
    mdl_seen    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset.alu_op_q", 32'(alu_op_q), 32'(OpAdd));
    check("reset.illegal_seen", 32'(illegal_seen), 32'h0);
    check("reset.comb_alu_op", 32'(alu_op), 32'(OpSub));
    @(negedge clk);
    rst_n = 1'b1;

    dir[0]  = '{2'b00, 32'hdeadbeef, 4'b0010, 1'b0};
    dir[1]  = '{2'b01, 32'h4000_7033, 4'b0110, 1'b0};
    dir[2]  = '{2'b10, 32'h0000_0000, 4'b0010, 1'b0};
    dir[3]  = '{2'b10, 32'h4000_0000, 4'b0110, 1'b0};
    dir[4]  = '{2'b10, 32'h0000_7000, 4'b0000, 1'b0};
    dir[5]  = '{2'b10, 32'h0011_6333, 4'b0001, 1'b0};
    dir[6]  = '{2'b10, 32'h4000_5033, 4'b1001, 1'b0};
    dir[7]  = '{2'b10, 32'h0000_5033, 4'b0101, 1'b0};
    dir[8]  = '{2'b10, 32'h0000_4033, 4'b0011, 1'b0};
    dir[9]  = '{2'b10, 32'h0000_2033, 4'b0111, 1'b0};
    dir[10] = '{2'b10, 32'h0000_3033, 4'b1000, 1'b0};
    dir[11] = '{2'b10, 32'h0000_1033, 4'b0100, 1'b0};
    dir[12] = '{2'b11, 32'h4000_0013, 4'b0010, 1'b0};
    dir[13] = '{2'b11, 32'h4000_5013, 4'b1001, 1'b0};
    dir[14] = '{2'b10, 32'h4000_7033, 4'b0010, 1'b1};
    dir[15] = '{2'b10, 32'h0200_0033, 4'b0010, 1'b1};

    for (int i = 0; i < 16; i++) begin
      step($sformatf("dir%0d", i), dir[i].sel, dir[i].ins, dir[i].op, dir[i].ill);
    end

    // Async reset mid-cycle, held across an edge while the decode is non-ADD.
    @(negedge clk);
    alu_op_sel = 2'b01;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    mdl_q    = OpAdd;
    mdl_seen = 1'b0;
    check("async_rst.alu_op_q", 32'(alu_op_q), 32'(mdl_q));
    check("async_rst.illegal_seen", 32'(illegal_seen), 32'(mdl_seen));
    @(posedge clk);
    #1;
    check("held_rst.alu_op_q", 32'(alu_op_q), 32'(mdl_q));
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 2'b01, 32'h0, OpSub, 1'b0);
    step("i_sll_bad", 2'b11, 32'h2000_1013, OpAdd, 1'b1);

    for (int i = 0; i < 300; i++) begin
      r_sel = 2'($urandom_range(0, 3));
      r_ins = $urandom;
      case ($urandom_range(0, 3))
        0:       r_ins[31:25] = 7'h00;
        1:       r_ins[31:25] = 7'h20;
        default: ;
      endcase
      ref_decode(r_sel, r_ins, m_op, m_ill);
      step($sformatf("rnd%0d", i), r_sel, r_ins, m_op, m_ill);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_control.md
# alu_control

Decodes the ALU operation for the RV32 single-cycle datapath. It takes the fetched instruction and the 2-bit ALU-op class from the main control unit and drives a 4-bit ALU operation code to the ALU. The decoded code is combinational, so it is valid in the same cycle as the instruction. Registered copies and an illegal-encoding flag are provided for pipeline/debug use.

## Interface
- No parameters.
- `clk`  input  1  system clock; only the registered outputs use it.
- `rst_n`  input  1  asynchronous, active-low reset.
- `instruction`  input  32  current instruction word.
- `alu_op_sel`  input  2  op class: 00 load/store/address add, 01 branch compare, 10 R-type, 11 I-type ALU.
- `alu_op`  output  4  combinational ALU operation code.
- `illegal`  output  1  combinational; high when the funct7/funct3 combination is not a valid ALU op for the selected class.
- `alu_op_q`  output  4  `alu_op` registered on the rising edge of `clk`.
- `illegal_seen`  output  1  sticky flag; set by any cycle with `illegal`=1, cleared only by reset.

## Operation
- ALU codes (shared constants):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 1001 SRA
  - 0111 SLT
  - 1000 SLTU
  - Other codes are never driven.
- Fields: funct3 = `instruction`[14:12]; funct7 = `instruction`[31:25]. Opcode bits [6:0] are ignored; the class comes solely from `alu_op_sel`.
- `alu_op_sel`=00: ADD, regardless of the instruction. `illegal`=0.
- `alu_op_sel`=01: SUB, regardless of the instruction. `illegal`=0.
- `alu_op_sel`=10 (R-type), by funct3:
  - 000: ADD if funct7=0000000; SUB if funct7=0100000.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL if funct7=0000000; SRA if funct7=0100000.
  - 110: OR.
  - 111: AND.
  - funct7=0100000 with funct3 not in {000,101}, or any other funct7 value: `illegal`=1 and `alu_op`=ADD.
- `alu_op_sel`=11 (I-type), by funct3:
  - 000: ADD (funct7 bits are immediate, never SUB).
  - 010: SLT. 011: SLTU. 100: XOR. 110: OR. 111: AND.
  - 001: SLL; requires funct7=0000000, otherwise illegal.
  - 101: SRL for funct7=0000000; SRA for funct7=0100000; otherwise illegal.
  - An illegal encoding drives `alu_op`=ADD.
- No X propagation: every input combination maps to a defined code.

## Timing
- `alu_op` and `illegal` are purely combinational and settle within the same cycle. There is no latency and no clock dependence.
- `alu_op_q` takes `alu_op` on every rising `clk` edge.
- `illegal_seen` sets on a rising edge when `illegal`=1. It stays set until reset.
- Reset (`rst_n` low, asynchronous, at any time including mid-operation):
  - `alu_op_q` = 0010 (ADD).
  - `illegal_seen` = 0.
  - Combinational outputs are unaffected by reset.
- On reset release, registers resume at the next rising edge.
- No handshake. The output follows input changes immediately.

## Structure
- The ALU code constants (enum `alu_op_t`, 4 bits) and the class encoding for `alu_op_sel` belong in a shared package, `alu_pkg`. The ALU imports the same package.
- funct3/funct7 field positions belong in the same package as constants.
- Single module; the decode is one combinational block plus two flops. A sub-module is not needed.

## Test plan
- `alu_op_sel`=00 with a random instruction → `alu_op`=0010, `illegal`=0. `alu_op_sel`=01 with a random instruction → 0110.
- `alu_op_sel`=10:
  - `instruction`=32'h00000000 → 0010.
  - 32'h40000000 → 0110.
  - 32'h00007000 → 0000.
  - 32'h00116333 → 0001.
- `alu_op_sel`=10:
  - 32'h40005033 → 1001 (SRA).
  - 32'h00005033 → 0101.
  - 32'h00004033 → 0011.
  - 32'h00002033 → 0111.
  - 32'h00003033 → 1000.
  - 32'h00001033 → 0100.
- Illegal encodings:
  - `alu_op_sel`=10 with 32'h40007033 → `alu_op`=0010, `illegal`=1; next rising edge sets `illegal_seen`=1.
  - `alu_op_sel`=10 with 32'h02000033 → illegal.
- `alu_op_sel`=11:
  - 32'h40000013 → 0010 (ADDI, no SUB).
  - 32'h40005013 → 1001.
  - 32'h20001013 → `illegal`=1.
- Reset:
  - Assert `rst_n`=0 between clock edges → `alu_op_q`=0010 and `illegal_seen`=0 immediately.
  - After release, `alu_op_q` tracks `alu_op` one edge later.
